// File: rtl/debounce_sync.sv
// Debounce and synchronize one raw asynchronous level input into a clean clk-domain level.
// Emits one-cycle rise/fall strobes and a busy flag while a candidate transition is being qualified.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_WIDTH     = 5
) (
    input  logic clk,
    input  logic async_reset_n,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_TO_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_TO_LOW  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_in;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 db_q, db_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 busy_q, busy_d;

    // Stage 0 samples raw_in; the FSM only ever looks at the last stage.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
        sync_in = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sync_in) begin
                    state_d = ST_TO_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_TO_HIGH: begin
                if (!sync_in) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_in) begin
                    state_d = ST_TO_LOW;
                    cnt_d   = '0;
                end
            end
            ST_TO_LOW: begin
                if (sync_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
        // busy is registered alongside the state so it tracks state_q exactly.
        busy_d = (state_d == ST_TO_HIGH) || (state_d == ST_TO_LOW);
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync_q  <= '0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: STABLE_CYCLES=4 and STABLE_CYCLES=1 instances.
// Pulse events are queued by the stimulus and matched by per-instance monitors.
module tb_debounce_sync;

    typedef struct {
        bit          rise;
        int unsigned cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    logic raw_a, raw_b;
    logic db_a, rise_a, fall_a, busy_a;
    logic db_b, rise_b, fall_b, busy_b;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit mon_en = 1'b0;
    ev_t q_a[$];
    ev_t q_b[$];

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_WIDTH(3)) u_dut_a (
        .clk(clk), .async_reset_n(rst_n), .raw_in(raw_a),
        .db_out(db_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .busy(busy_a)
    );

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_WIDTH(1)) u_dut_b (
        .clk(clk), .async_reset_n(rst_n), .raw_in(raw_b),
        .db_out(db_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every observed pulse must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en && (rise_a || fall_a)) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL pulse_a: unexpected rise=%0d fall=%0d at cyc %0d", rise_a, fall_a, cyc);
            end else begin
                ev_t e;
                e = q_a.pop_front();
                if (rise_a !== e.rise || fall_a !== !e.rise || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse_a: got rise=%0d fall=%0d cyc=%0d expected rise=%0d fall=%0d cyc=%0d",
                             rise_a, fall_a, cyc, e.rise, !e.rise, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && (rise_b || fall_b)) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL pulse_b: unexpected rise=%0d fall=%0d at cyc %0d", rise_b, fall_b, cyc);
            end else begin
                ev_t e;
                e = q_b.pop_front();
                if (rise_b !== e.rise || fall_b !== !e.rise || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse_b: got rise=%0d fall=%0d cyc=%0d expected rise=%0d fall=%0d cyc=%0d",
                             rise_b, fall_b, cyc, e.rise, !e.rise, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned k;
        int unsigned c;
        bit pat [6];
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b1;
        raw_a = 1'b1;
        raw_b = 1'b1;

        // Asynchronous reset between edges with raw_in high.
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_a", {db_a, rise_a, fall_a, busy_a}, 0);
        chk("reset_async_b", {db_b, rise_b, fall_b, busy_b}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_a", {db_a, rise_a, fall_a, busy_a}, 0);
            chk("reset_hold_b", {db_b, rise_b, fall_b, busy_b}, 0);
        end
        raw_a = 1'b0;
        raw_b = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_a", {db_a, busy_a}, 0);
        chk("idle_b", {db_b, busy_b}, 0);

        // Clean rise: edge E0 = k+1, acceptance after E0+6 (A) and E0+3 (B).
        k = cyc;
        raw_a = 1'b1;
        raw_b = 1'b1;
        q_a.push_back('{rise: 1'b1, cyc: k + 7});
        q_b.push_back('{rise: 1'b1, cyc: k + 4});
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            c = cyc;
            chk("rise_busy_a", busy_a, (c >= k + 3 && c <= k + 6) ? 1 : 0);
            chk("rise_db_a", db_a, (c >= k + 7) ? 1 : 0);
            chk("rise_busy_b", busy_b, (c == k + 3) ? 1 : 0);
            chk("rise_db_b", db_b, (c >= k + 4) ? 1 : 0);
        end

        // Clean fall from db_out=1.
        k = cyc;
        raw_a = 1'b0;
        raw_b = 1'b0;
        q_a.push_back('{rise: 1'b0, cyc: k + 7});
        q_b.push_back('{rise: 1'b0, cyc: k + 4});
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            c = cyc;
            chk("fall_busy_a", busy_a, (c >= k + 3 && c <= k + 6) ? 1 : 0);
            chk("fall_db_a", db_a, (c < k + 7) ? 1 : 0);
            chk("fall_busy_b", busy_b, (c == k + 3) ? 1 : 0);
            chk("fall_db_b", db_b, (c < k + 4) ? 1 : 0);
        end

        // Bounce on A only: high 3, low 1, high 2, then low; never qualifies.
        for (int i = 0; i < 6; i++) begin
            raw_a = pat[i];
            @(negedge clk);
            chk("bounce_db_a", db_a, 0);
        end
        raw_a = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("bounce_db_a", db_a, 0);
        end
        chk("bounce_busy_a", busy_a, 0);

        // Reset while A is in TO_HIGH with counter=2; count must restart from scratch.
        k = cyc;
        raw_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("midq_busy_pre_a", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midq_reset_a", {db_a, rise_a, fall_a, busy_a}, 0);
        #1 rst_n = 1'b1;
        k = cyc;
        q_a.push_back('{rise: 1'b1, cyc: k + 7});
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            c = cyc;
            chk("midq_busy_a", busy_a, (c >= k + 3 && c <= k + 6) ? 1 : 0);
            chk("midq_db_a", db_a, (c >= k + 7) ? 1 : 0);
            chk("midq_db_b", db_b, 0);
        end

        repeat (6) @(negedge clk);
        chk("pending_a", q_a.size(), 0);
        chk("pending_b", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
